// File: rtl/composite_video_pkg.sv
// Shared types and constants for the composite video framebuffer path.
// Pixel levels map bit1 to the 450 ohm leg and bit0 to the 900 ohm leg.
package composite_video_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 2;
    localparam int PIXELS_PER_LINE = 256;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_VIDEO = 2'd1,
        TAG_HOST  = 2'd2
    } tag_e;

    localparam logic [1:0] SYNC  = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b11;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Scanout prefetch FIFO with flush and a first-word-fall-through head.
// The head holds the last popped word once the FIFO drains.
module fb_prefetch_fifo #(
    parameter int DATA_W = composite_video_pkg::DATA_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    occupancy,
    output logic              empty
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] last_q;
    logic              do_pop;

    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign occupancy = count;
    assign head      = empty ? last_q : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= store[rd_ptr];
            end
            if (push && !do_pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!push && do_pop) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/composite_fb_arbiter.sv
// Single-port framebuffer scheduler: hard real-time scanout prefetch plus host port.
// Define FB_ARB_HOST_GUARD_EN to let a starved host steal a slot from a healthy FIFO.
module composite_fb_arbiter
    import composite_video_pkg::*;
#(
    parameter int ADDR_W          = composite_video_pkg::ADDR_W,
    parameter int DATA_W          = composite_video_pkg::DATA_W,
    parameter int PIXELS_PER_LINE = composite_video_pkg::PIXELS_PER_LINE,
    parameter int PREFETCH_DEPTH  = 4,
    parameter int HOST_MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OCC_W = $clog2(PREFETCH_DEPTH) + 1;
    localparam int REM_W = $clog2(PIXELS_PER_LINE + 1);
    localparam logic [OCC_W:0]   DEPTH_C = (OCC_W+1)'(PREFETCH_DEPTH);
    localparam logic [REM_W-1:0] LINE_C  = REM_W'(PIXELS_PER_LINE);

    logic [ADDR_W-1:0] fetch_ptr;
    logic [REM_W-1:0]  fetch_rem;
    tag_e              tag_q;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    committed;
    logic              fifo_empty;
    logic              underrun_q;
    logic              slot_open;
    logic              video_ok;
    logic              guard_fire;
    logic              video_go;
    logic              host_go;
    logic              push;

    assign slot_open = !reset && !line_start;
    // A read in flight already owns a FIFO entry.
    assign committed = {1'b0, occ} + (OCC_W+1)'(tag_q == TAG_VIDEO);
    assign video_ok  = slot_open && (fetch_rem != '0)
                     && (committed < DEPTH_C);

`ifdef FB_ARB_HOST_GUARD_EN
    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_C = WAIT_W'(HOST_MAX_WAIT);

    logic [WAIT_W-1:0] wait_q;

    assign guard_fire = slot_open && host_valid
                      && (wait_q == WAIT_C) && (occ >= OCC_W'(2));

    always_ff @(posedge clk) begin
        if (reset || host_go) begin
            wait_q <= '0;
        end else if (host_valid && wait_q != WAIT_C) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end
`else
    assign guard_fire = 1'b0;
`endif

    assign video_go   = video_ok && !guard_fire;
    assign host_go    = slot_open && host_valid && !video_go;
    assign host_ready = host_go;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            video_go: begin
                mem_en   = 1'b1;
                mem_addr = fetch_ptr;
            end
            host_go: begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    // Returns landing on a line_start or reset cycle are stale.
    assign push        = slot_open && (tag_q == TAG_VIDEO);
    assign host_rvalid = !reset && (tag_q == TAG_HOST);
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign pix_valid   = !fifo_empty;
    assign underrun    = underrun_q;

    fb_prefetch_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (PREFETCH_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (line_start),
        .push     (push),
        .push_data(mem_rdata),
        .pop      (pix_req),
        .head     (pix_data),
        .occupancy(occ),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_ptr  <= '0;
            fetch_rem  <= '0;
            tag_q      <= TAG_NONE;
            underrun_q <= 1'b0;
        end else begin
            if (pix_req && fifo_empty) begin
                underrun_q <= 1'b1;
            end
            if (line_start) begin
                fetch_ptr <= line_base;
                fetch_rem <= LINE_C;
                tag_q     <= TAG_NONE;
            end else begin
                if (video_go) begin
                    fetch_ptr <= fetch_ptr + ADDR_W'(1);
                    fetch_rem <= fetch_rem - REM_W'(1);
                end
                if (video_go) begin
                    tag_q <= TAG_VIDEO;
                end else if (host_go && !host_we) begin
                    tag_q <= TAG_HOST;
                end else begin
                    tag_q <= TAG_NONE;
                end
            end
        end
    end

endmodule
